// File: rtl/mem_loader_pkg.sv
// Shared types and width constants for the operand-RAM loader and the read stage.
// Holds the loader state encoding and the bytes-per-word helper.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FINISH  = 2'd2
  } state_t;

  // Default operand word is 16 bits, i.e. two bytes.
  localparam int BYTES_PER_WORD = 2;

  function automatic int bytes_per_word(input int dbits);
    return dbits / 8;
  endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Little-endian byte packer: assembles DBITS-wide words from a byte strobe.
// Completed word is registered; word_vld pulses the cycle after the last byte.
module mem_loader_packer
  import mem_loader_pkg::*;
#(
  parameter int DBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             byte_vld,
  input  logic [7:0]       byte_dat,
  output logic             word_last,
  output logic             word_vld,
  output logic [DBITS-1:0] word_dat
);

  localparam int BPW = bytes_per_word(DBITS);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]    byte_cnt;
  logic [DBITS-1:0] pack;
  logic [DBITS-1:0] pack_nxt;

  // The completing byte is merged combinationally so the written word includes it.
  always_comb begin
    pack_nxt = pack;
    pack_nxt[8*byte_cnt +: 8] = byte_dat;
    word_last = byte_vld && (byte_cnt == CW'(BPW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      pack     <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      pack     <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= word_last;
      if (byte_vld) begin
        pack <= pack_nxt;
        if (word_last) begin
          byte_cnt <= '0;
          word_dat <= pack_nxt;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Loads NWORDS packed words from the UART byte stream into the operand RAM at BASE_ADDR.
// Reports done after the final write, or error when the inter-byte gap reaches TIMEOUT-1.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ABITS     = 8,
  parameter int DBITS     = 8 * BYTES_PER_WORD,
  parameter int NWORDS    = 16,
  parameter int BASE_ADDR = 0,
  parameter int TIMEOUT   = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             wr_en,
  output logic [ABITS-1:0] wr_addr,
  output logic [DBITS-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = ABITS + 1;

  state_t           state_q, state_d;
  logic [ABITS-1:0] addr_q;
  logic [WW-1:0]    word_cnt_q;
  logic [TW-1:0]    tmo_q;

  logic accept;
  logic word_last;
  logic last_word;
  logic timeout_hit;
  logic load_start;
  logic clear;
  logic done_d;
  logic error_d;

  assign accept      = (state_q == COLLECT) && rx_valid;
  assign load_start  = (state_q == IDLE) && start;
  // Fires on the idle cycle that brings tmo to TIMEOUT-1; a byte in that cycle wins.
  assign timeout_hit = (state_q == COLLECT) && !rx_valid && (tmo_q == TW'(TIMEOUT - 2));
  assign last_word   = word_last && (word_cnt_q == WW'(NWORDS - 1));
  assign clear       = load_start || timeout_hit;

  mem_loader_packer #(
    .DBITS(DBITS)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .byte_vld (accept),
    .byte_dat (rx_data),
    .word_last(word_last),
    .word_vld (wr_en),
    .word_dat (wr_data)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        if (timeout_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (last_word) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        // Final wr_en is on the wire this cycle; done follows with busy already low.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_ready <= (state_d == COLLECT);
      busy     <= (state_d != IDLE);
      done     <= done_d;
      error    <= error_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      wr_addr    <= '0;
    end else if (load_start) begin
      addr_q     <= ABITS'(BASE_ADDR);
      word_cnt_q <= '0;
      tmo_q      <= '0;
    end else if (state_q == COLLECT) begin
      tmo_q <= rx_valid ? '0 : tmo_q + 1'b1;
      if (word_last) begin
        wr_addr    <= addr_q;
        addr_q     <= addr_q + 1'b1;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: three instances (defaults, short load with short timeout,
// address wrap) share the byte bus; each step compares outputs to hand-computed values.
module tb_mem_loader;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       start0, start1, start2;

  logic        rx_ready0, wr_en0, busy0, done0, error0;
  logic [7:0]  wr_addr0;
  logic [15:0] wr_data0;
  logic        rx_ready1, wr_en1, busy1, done1, error1;
  logic [7:0]  wr_addr1;
  logic [15:0] wr_data1;
  logic        rx_ready2, wr_en2, busy2, done2, error2;
  logic [7:0]  wr_addr2;
  logic [15:0] wr_data2;

  int checks   = 0;
  int failures = 0;
  int cnt0 = 0, cnt1 = 0, cnt2 = 0;

  mem_loader u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .error(error0)
  );

  mem_loader #(.NWORDS(2), .TIMEOUT(10)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .error(error1)
  );

  mem_loader #(.NWORDS(3), .BASE_ADDR(254)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .done(done2), .error(error2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en0) cnt0++;
    if (wr_en1) cnt1++;
    if (wr_en2) cnt2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    #12;
    chk("reset_ctl0", {28'd0, busy0, rx_ready0, done0, error0}, 32'h0);
    chk("reset_wr0", {7'd0, wr_en0, wr_addr0, wr_data0}, 32'h0);
    chk("reset_busy12", {30'd0, busy1, busy2}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Default instance: gapped bytes, start while busy ignored, full 16-word load.
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("a_busy_ready", {30'd0, busy0, rx_ready0}, 32'h3);
    send_byte(8'h34);
    chk("a_no_wr_half", {31'd0, wr_en0}, 32'h0);
    tick(); tick(); tick();
    send_byte(8'h12);
    chk("a_w0", {7'd0, wr_en0, wr_addr0, wr_data0}, {7'd0, 1'b1, 8'd0, 16'h1234});
    tick();
    chk("a_w0_hold", {7'd0, wr_en0, wr_addr0, wr_data0}, {7'd0, 1'b0, 8'd0, 16'h1234});
    start0 = 1'b1; tick(); start0 = 1'b0;
    send_byte(8'h78);
    send_byte(8'h56);
    chk("a_w1", {7'd0, wr_en0, wr_addr0, wr_data0}, {7'd0, 1'b1, 8'd1, 16'h5678});
    for (int w = 2; w < 16; w++) begin
      send_byte(8'(w));
      send_byte(8'(8'hA0 + w));
    end
    chk("a_w15", {7'd0, wr_en0, wr_addr0, wr_data0}, {7'd0, 1'b1, 8'd15, 16'hAF0F});
    chk("a_fin_busy", {30'd0, busy0, done0}, 32'h2);
    tick();
    chk("a_done", {28'd0, wr_en0, busy0, done0, error0}, 32'h2);
    tick();
    chk("a_done_pulse", {31'd0, done0}, 32'h0);
    chk("a_counts", {cnt0[7:0], cnt1[7:0], cnt2[7:0], 8'd0}, {8'd16, 8'd0, 8'd0, 8'd0});

    // Two words from back-to-back bytes.
    start1 = 1'b1; tick(); start1 = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h01; tick();
    rx_data = 8'h02; tick();
    chk("b_w0", {7'd0, wr_en1, wr_addr1, wr_data1}, {7'd0, 1'b1, 8'd0, 16'h0201});
    rx_data = 8'h03; tick();
    chk("b_gap", {31'd0, wr_en1}, 32'h0);
    rx_data = 8'h04; tick();
    rx_valid = 1'b0;
    chk("b_w1", {7'd0, wr_en1, wr_addr1, wr_data1}, {7'd0, 1'b1, 8'd1, 16'h0403});
    chk("b_fin", {29'd0, busy1, done1, error1}, 32'h4);
    tick();
    chk("b_done", {28'd0, wr_en1, busy1, done1, error1}, 32'h2);

    // Timeout: one byte then silence; error 9 clocks after the byte.
    start1 = 1'b1; tick(); start1 = 1'b0;
    send_byte(8'hAA);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("c_quiet", {29'd0, error1, wr_en1, busy1}, 32'h1);
    end
    tick();
    chk("c_error", {28'd0, error1, wr_en1, busy1, rx_ready1}, 32'h8);
    tick();
    chk("c_error_pulse", {30'd0, error1, busy1}, 32'h0);
    chk("c_count", cnt1, 32'd2);

    // Reload after timeout, junk and start during FINISH/done ignored.
    start1 = 1'b1; tick(); start1 = 1'b0;
    send_byte(8'h11); send_byte(8'h22);
    chk("d_w0", {7'd0, wr_en1, wr_addr1, wr_data1}, {7'd0, 1'b1, 8'd0, 16'h2211});
    send_byte(8'h33); send_byte(8'h44);
    chk("d_w1", {7'd0, wr_en1, wr_addr1, wr_data1}, {7'd0, 1'b1, 8'd1, 16'h4433});
    rx_valid = 1'b1; rx_data = 8'h55; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("d_done", {29'd0, busy1, done1, wr_en1}, 32'h2);
    tick(); tick();
    rx_valid = 1'b0;
    chk("d_idle", {7'd0, busy1, wr_en1, rx_ready1, wr_data1, 6'd0},
        {7'd0, 1'b0, 1'b0, 1'b0, 16'h4433, 6'd0});
    chk("d_count", cnt1, 32'd4);

    // Address wrap: 254, 255, 0.
    start2 = 1'b1; tick(); start2 = 1'b0;
    send_byte(8'hAA); send_byte(8'hBB);
    chk("e_w0", {7'd0, wr_en2, wr_addr2, wr_data2}, {7'd0, 1'b1, 8'd254, 16'hBBAA});
    send_byte(8'hCC); send_byte(8'hDD);
    chk("e_w1", {7'd0, wr_en2, wr_addr2, wr_data2}, {7'd0, 1'b1, 8'd255, 16'hDDCC});
    send_byte(8'hEE); send_byte(8'hFF);
    chk("e_w2", {7'd0, wr_en2, wr_addr2, wr_data2}, {7'd0, 1'b1, 8'd0, 16'hFFEE});
    tick();
    chk("e_done", {29'd0, busy2, done2, error2}, 32'h2);

    // Reset mid-load clears outputs asynchronously; following load is clean.
    start2 = 1'b1; tick(); start2 = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    chk("f_pre", {7'd0, busy2, wr_addr2, wr_data2}, {7'd0, 1'b1, 8'd254, 16'h0201});
    rst_n = 1'b0;
    #2;
    chk("f_rst_ctl", {27'd0, busy2, rx_ready2, wr_en2, done2, error2}, 32'h0);
    chk("f_rst_wr", {8'd0, wr_addr2, wr_data2}, 32'h0);
    rst_n = 1'b1;
    tick();
    start2 = 1'b1; tick(); start2 = 1'b0;
    send_byte(8'h10); send_byte(8'h20);
    chk("f_w0", {7'd0, wr_en2, wr_addr2, wr_data2}, {7'd0, 1'b1, 8'd254, 16'h2010});
    send_byte(8'h30); send_byte(8'h40);
    chk("f_w1", {7'd0, wr_en2, wr_addr2, wr_data2}, {7'd0, 1'b1, 8'd255, 16'h4030});
    send_byte(8'h50); send_byte(8'h60);
    chk("f_w2", {7'd0, wr_en2, wr_addr2, wr_data2}, {7'd0, 1'b1, 8'd0, 16'h6050});
    tick();
    chk("f_done", {29'd0, busy2, done2, error2}, 32'h2);
    tick();
    chk("f_counts", {cnt0[7:0], cnt1[7:0], cnt2[7:0], 8'd0}, {8'd16, 8'd4, 8'd7, 8'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
